// File: rtl/operand_fetch_pkg.sv
// operand_fetch_pkg: shared widths, register count, output-stage state type and register-index compare helper
package operand_fetch_pkg;
  localparam int ADDR_W = 8;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W = 8;
  localparam int NREG = 32;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [REG_IDX_W-1:0] idx_t;
  typedef enum logic {EMPTY, FULL} ostate_e;
  localparam addr_t IDX_MASK = addr_t'((1 << REG_IDX_W) - 1);
  function automatic logic same_reg(addr_t a, addr_t b);
    return ((a ^ b) & IDX_MASK) == '0;
  endfunction
endpackage

// File: rtl/operand_fetch_if.sv
// operand_fetch_if: bundle of the stage's instruction, register-file, writeback and output buses; master drives the stage, slave is the stage
interface operand_fetch_if #(parameter int DATA_W = operand_fetch_pkg::DATA_W);
  import operand_fetch_pkg::*;
  logic in_valid, in_ready, in_rd_we;
  addr_t in_rs1, in_rs2, in_rd, rf_a1, rf_a2, wb_addr, out_rd;
  logic [DATA_W-1:0] rf_rd1, rf_rd2, wb_data, out_op1, out_op2;
  logic wb_valid, flush, out_valid, out_ready, out_rd_we;
  logic [15:0] stall_count;
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_rd_we, rf_rd1, rf_rd2, wb_valid, wb_addr, wb_data, flush, out_ready,
    input in_ready, rf_a1, rf_a2, out_valid, out_op1, out_op2, out_rd, out_rd_we, stall_count
  );
  modport slave (
    input in_valid, in_rs1, in_rs2, in_rd, in_rd_we, rf_rd1, rf_rd2, wb_valid, wb_addr, wb_data, flush, out_ready,
    output in_ready, rf_a1, rf_a2, out_valid, out_op1, out_op2, out_rd, out_rd_we, stall_count
  );
endinterface

// File: rtl/operand_scoreboard.sv
// operand_scoreboard: per-register busy bits (set on issue, clear on writeback, set wins, flush clears all); three lookups report busy-and-not-written-back-this-cycle
module operand_scoreboard import operand_fetch_pkg::*; #(
  parameter int NREG = operand_fetch_pkg::NREG
) (
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic set_en,
  input  idx_t set_idx,
  input  logic clr_en,
  input  idx_t clr_idx,
  input  idx_t q1_idx,
  input  idx_t q2_idx,
  input  idx_t q3_idx,
  output logic q1_pend,
  output logic q2_pend,
  output logic q3_pend
);
  logic [NREG-1:0] busy_q, busy_d, set_m, clr_m;
  always_comb begin
    set_m = set_en ? NREG'(1) << set_idx : '0;
    clr_m = clr_en ? NREG'(1) << clr_idx : '0;
    busy_d = flush ? '0 : (busy_q & ~clr_m) | set_m;
    q1_pend = busy_q[q1_idx] & ~(clr_en & (clr_idx == q1_idx));
    q2_pend = busy_q[q2_idx] & ~(clr_en & (clr_idx == q2_idx));
    q3_pend = busy_q[q3_idx] & ~(clr_en & (clr_idx == q3_idx));
  end
  always_ff @(posedge clk) busy_q <= reset ? '0 : busy_d;
endmodule

// File: rtl/operand_fetch.sv
// operand_fetch: one-entry operand stage; reads rf via rf_a*/rf_rd*, forwards wb_data, stalls on scoreboard hazards, holds out_* under backpressure, counts stalls
module operand_fetch import operand_fetch_pkg::*; #(
  parameter int DATA_W = operand_fetch_pkg::DATA_W,
  parameter int NREG = operand_fetch_pkg::NREG
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  addr_t             in_rs1,
  input  addr_t             in_rs2,
  input  addr_t             in_rd,
  input  logic              in_rd_we,
  output addr_t             rf_a1,
  output addr_t             rf_a2,
  input  logic [DATA_W-1:0] rf_rd1,
  input  logic [DATA_W-1:0] rf_rd2,
  input  logic              wb_valid,
  input  addr_t             wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output addr_t             out_rd,
  output logic              out_rd_we,
  output logic [15:0]       stall_count
);
  ostate_e state_q, state_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d;
  addr_t rd_q, rd_d;
  logic rd_we_q, rd_we_d;
  logic [15:0] stall_q, stall_d;
  logic p1, p2, p3, hazard, accept, fwd1, fwd2;
  operand_scoreboard #(.NREG(NREG)) u_sb (
    .clk(clk),
    .reset(reset),
    .flush(flush),
    .set_en(accept & in_rd_we),
    .set_idx(in_rd[REG_IDX_W-1:0]),
    .clr_en(wb_valid),
    .clr_idx(wb_addr[REG_IDX_W-1:0]),
    .q1_idx(in_rs1[REG_IDX_W-1:0]),
    .q2_idx(in_rs2[REG_IDX_W-1:0]),
    .q3_idx(in_rd[REG_IDX_W-1:0]),
    .q1_pend(p1),
    .q2_pend(p2),
    .q3_pend(p3)
  );
  always_comb begin
    rf_a1 = in_rs1;
    rf_a2 = in_rs2;
    out_valid = state_q == FULL;
    out_op1 = op1_q;
    out_op2 = op2_q;
    out_rd = rd_q;
    out_rd_we = rd_we_q;
    stall_count = stall_q;
    hazard = p1 | p2 | (in_rd_we & p3);
    in_ready = (~out_valid | out_ready) & ~hazard & ~flush & ~reset;
    accept = in_valid & in_ready;
    fwd1 = wb_valid & same_reg(wb_addr, in_rs1);
    fwd2 = wb_valid & same_reg(wb_addr, in_rs2);
    state_d = flush ? EMPTY : accept ? FULL : out_ready ? EMPTY : state_q;
    op1_d = accept ? (fwd1 ? wb_data : rf_rd1) : op1_q;
    op2_d = accept ? (fwd2 ? wb_data : rf_rd2) : op2_q;
    rd_d = accept ? in_rd : rd_q;
    rd_we_d = accept ? in_rd_we : rd_we_q;
    stall_d = (in_valid & ~in_ready & (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      op1_q <= '0;
      op2_q <= '0;
      rd_q <= '0;
      rd_we_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      rd_q <= rd_d;
      rd_we_q <= rd_we_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: table vectors, hand sequences for multi-cycle corners, then random stimulus against a register-level reference model
module tb_operand_fetch;
  import operand_fetch_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  operand_fetch_if bus ();
  logic [7:0] rf [32];
  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(bus.in_valid), .in_ready(bus.in_ready),
    .in_rs1(bus.in_rs1), .in_rs2(bus.in_rs2), .in_rd(bus.in_rd), .in_rd_we(bus.in_rd_we),
    .rf_a1(bus.rf_a1), .rf_a2(bus.rf_a2), .rf_rd1(bus.rf_rd1), .rf_rd2(bus.rf_rd2),
    .wb_valid(bus.wb_valid), .wb_addr(bus.wb_addr), .wb_data(bus.wb_data),
    .flush(bus.flush),
    .out_valid(bus.out_valid), .out_ready(bus.out_ready),
    .out_op1(bus.out_op1), .out_op2(bus.out_op2),
    .out_rd(bus.out_rd), .out_rd_we(bus.out_rd_we),
    .stall_count(bus.stall_count)
  );
  assign bus.rf_rd1 = rf[bus.rf_a1[4:0]];
  assign bus.rf_rd2 = rf[bus.rf_a2[4:0]];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) rf[i] <= i == 3 ? 8'h11 : i == 4 ? 8'h22 : 8'(8'h40 + i);
    end else if (bus.wb_valid) begin
      rf[bus.wb_addr[4:0]] <= bus.wb_data;
    end
  end
  int total = 0;
  int bad = 0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic drive(input logic v, input logic [7:0] rs1, input logic [7:0] rs2, input logic [7:0] rd,
                       input logic we, input logic wbv, input logic [7:0] wba, input logic [7:0] wbd,
                       input logic fl, input logic ordy);
    @(negedge clk);
    bus.in_valid = v; bus.in_rs1 = rs1; bus.in_rs2 = rs2; bus.in_rd = rd; bus.in_rd_we = we;
    bus.wb_valid = wbv; bus.wb_addr = wba; bus.wb_data = wbd; bus.flush = fl; bus.out_ready = ordy;
    #1;
  endtask
  task automatic edge_wait();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic v; logic [7:0] rs1, rs2, rd; logic we, wbv; logic [7:0] wba, wbd; logic fl, ordy;
    logic e_rdy, e_ov; logic [7:0] e_op1, e_op2; logic [15:0] e_st;
  } vec_t;
  vec_t tab [15];
  bit [31:0] mb;
  logic m_ov, m_we, hz, er, acc;
  logic [7:0] m_op1, m_op2, m_rd, e1, e2;
  int m_stall;
  logic v, we, wbv, fl, ordy;
  logic [7:0] rs1, rs2, rd, wba, wbd;
  initial begin
    tab[0]  = '{1'b1, 8'h03, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 16'd0};
    tab[1]  = '{1'b1, 8'h00, 8'h00, 8'h07, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h40, 16'd0};
    tab[2]  = '{1'b1, 8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd1};
    tab[3]  = '{1'b1, 8'h00, 8'h07, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 16'd2};
    tab[4]  = '{1'b1, 8'h00, 8'h07, 8'h00, 1'b0, 1'b1, 8'h07, 8'h77, 1'b0, 1'b1, 1'b1, 1'b1, 8'h40, 8'h77, 16'd2};
    tab[5]  = '{1'b1, 8'h01, 8'h01, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h41, 8'h41, 16'd2};
    tab[6]  = '{1'b1, 8'h05, 8'h04, 8'h00, 1'b0, 1'b1, 8'h05, 8'hA5, 1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 8'h22, 16'd2};
    tab[7]  = '{1'b1, 8'hE3, 8'h24, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h22, 16'd2};
    tab[8]  = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 16'd3};
    tab[9]  = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 16'd4};
    tab[10] = '{1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11, 8'h22, 16'd5};
    tab[11] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 16'd5};
    tab[12] = '{1'b1, 8'h03, 8'h03, 8'h02, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h11, 16'd5};
    tab[13] = '{1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 16'd6};
    tab[14] = '{1'b1, 8'h02, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'h42, 8'h42, 16'd6};
    reset = 1'b1;
    drive(1'b1, 8'h03, 8'h04, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("reset_in_ready", 32'(bus.in_ready), 32'd0);
    edge_wait();
    edge_wait();
    chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset_op1", 32'(bus.out_op1), 32'd0);
    chk("reset_op2", 32'(bus.out_op2), 32'd0);
    chk("reset_rd", 32'(bus.out_rd), 32'd0);
    chk("reset_stall", 32'(bus.stall_count), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(tab[i].v, tab[i].rs1, tab[i].rs2, tab[i].rd, tab[i].we, tab[i].wbv, tab[i].wba, tab[i].wbd, tab[i].fl, tab[i].ordy);
      chk($sformatf("tab%0d_in_ready", i), 32'(bus.in_ready), 32'(tab[i].e_rdy));
      edge_wait();
      chk($sformatf("tab%0d_out_valid", i), 32'(bus.out_valid), 32'(tab[i].e_ov));
      chk($sformatf("tab%0d_stall", i), 32'(bus.stall_count), 32'(tab[i].e_st));
      if (tab[i].e_ov) begin
        chk($sformatf("tab%0d_op1", i), 32'(bus.out_op1), 32'(tab[i].e_op1));
        chk($sformatf("tab%0d_op2", i), 32'(bus.out_op2), 32'(tab[i].e_op2));
      end
    end
    drive(1'b1, 8'h00, 8'h00, 8'h09, 1'b1, 1'b1, 8'h09, 8'h99, 1'b0, 1'b1);
    chk("setclr_accept", 32'(bus.in_ready), 32'd1);
    edge_wait();
    chk("setclr_out_rd", 32'(bus.out_rd), 32'h09);
    chk("setclr_out_rd_we", 32'(bus.out_rd_we), 32'd1);
    drive(1'b1, 8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("setclr_set_wins", 32'(bus.in_ready), 32'd0);
    edge_wait();
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 8'h29, 8'h5A, 1'b0, 1'b1);
    edge_wait();
    drive(1'b1, 8'h09, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("wbalias_ready", 32'(bus.in_ready), 32'd1);
    edge_wait();
    chk("wbalias_op1", 32'(bus.out_op1), 32'h5A);
    drive(1'b1, 8'h03, 8'h04, 8'h05, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    edge_wait();
    drive(1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    edge_wait();
    chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
    reset = 1'b1;
    drive(1'b1, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("midreset_in_ready", 32'(bus.in_ready), 32'd0);
    edge_wait();
    chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midreset_op1", 32'(bus.out_op1), 32'd0);
    chk("midreset_op2", 32'(bus.out_op2), 32'd0);
    chk("midreset_rd", 32'(bus.out_rd), 32'd0);
    chk("midreset_rd_we", 32'(bus.out_rd_we), 32'd0);
    chk("midreset_stall", 32'(bus.stall_count), 32'd0);
    reset = 1'b0;
    drive(1'b1, 8'h05, 8'h05, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("midreset_busy_cleared", 32'(bus.in_ready), 32'd1);
    edge_wait();
    chk("midreset_op1_after", 32'(bus.out_op1), 32'h45);
    reset = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    edge_wait();
    reset = 1'b0;
    mb = '0; m_ov = 1'b0; m_we = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_stall = 0;
    for (int c = 0; c < 400; c++) begin
      v = ($urandom % 5) != 0;
      rs1 = {3'($urandom), 5'($urandom_range(0, 7))};
      rs2 = {3'($urandom), 5'($urandom_range(0, 7))};
      rd = {3'($urandom), 5'($urandom_range(0, 7))};
      we = 1'($urandom);
      wbv = ($urandom % 3) == 0;
      wba = {3'($urandom), 5'($urandom_range(0, 7))};
      wbd = 8'($urandom);
      fl = ($urandom % 30) == 0;
      ordy = ($urandom % 4) != 0;
      drive(v, rs1, rs2, rd, we, wbv, wba, wbd, fl, ordy);
      hz = (mb[rs1[4:0]] && !(wbv && wba[4:0] == rs1[4:0])) ||
           (mb[rs2[4:0]] && !(wbv && wba[4:0] == rs2[4:0])) ||
           (we && mb[rd[4:0]] && !(wbv && wba[4:0] == rd[4:0]));
      er = (!m_ov || ordy) && !hz && !fl;
      chk($sformatf("rnd%0d_in_ready", c), 32'(bus.in_ready), 32'(er));
      acc = v && er;
      e1 = (wbv && wba[4:0] == rs1[4:0]) ? wbd : rf[rs1[4:0]];
      e2 = (wbv && wba[4:0] == rs2[4:0]) ? wbd : rf[rs2[4:0]];
      if (v && !er && m_stall < 65535) m_stall++;
      if (fl) begin
        mb = '0;
        m_ov = 1'b0;
      end else begin
        if (wbv) mb[wba[4:0]] = 1'b0;
        if (acc && we) mb[rd[4:0]] = 1'b1;
        if (acc) begin
          m_ov = 1'b1; m_op1 = e1; m_op2 = e2; m_rd = rd; m_we = we;
        end else if (ordy) begin
          m_ov = 1'b0;
        end
      end
      edge_wait();
      chk($sformatf("rnd%0d_out_valid", c), 32'(bus.out_valid), 32'(m_ov));
      chk($sformatf("rnd%0d_stall", c), 32'(bus.stall_count), 32'(m_stall));
      if (m_ov) begin
        chk($sformatf("rnd%0d_op1", c), 32'(bus.out_op1), 32'(m_op1));
        chk($sformatf("rnd%0d_op2", c), 32'(bus.out_op2), 32'(m_op2));
        chk($sformatf("rnd%0d_rd", c), 32'(bus.out_rd), 32'(m_rd));
        chk($sformatf("rnd%0d_rd_we", c), 32'(bus.out_rd_we), 32'(m_we));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
